// File: rtl/nibble_seq_adder_pkg.sv
// nibble_seq_adder_pkg: shared FSM encoding and default slice count for nibble_seq_adder
package nibble_seq_adder_pkg;
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;
    localparam int NIBBLES_DEF = 4;
endpackage

// File: rtl/nibble_seq_adder_if.sv
// nibble_seq_adder_if: request/result bundle of nibble_seq_adder
//   i_start : request to begin an addition (sampled in IDLE only)
//   i_a/i_b : W-bit operands, i_cin : carry-in
//   o_busy  : high in RUN and DONE, o_done : one-cycle result-valid pulse
//   o_sum   : W-bit registered result, o_cout : registered carry-out
interface nibble_seq_adder_if #(parameter int W = 16);
    logic         i_start;
    logic [W-1:0] i_a;
    logic [W-1:0] i_b;
    logic         i_cin;
    logic         o_busy;
    logic         o_done;
    logic [W-1:0] o_sum;
    logic         o_cout;
    modport master (output i_start, i_a, i_b, i_cin, input o_busy, o_done, o_sum, o_cout);
    modport slave  (input i_start, i_a, i_b, i_cin, output o_busy, o_done, o_sum, o_cout);
endinterface

// File: rtl/nibble_seq_adder_adder4bit.sv
// Adder4bit: purely combinational 4-bit ripple-carry adder
//   i_a/i_b : 4-bit addends, i_cin : carry-in
//   o_sum   : 4-bit sum, o_cout : carry out of bit 3
module Adder4bit (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic       i_cin,
    output logic [3:0] o_sum,
    output logic       o_cout
);
    logic [4:0] w_c;
    assign w_c[0] = i_cin;
    for (genvar g = 0; g < 4; g++) begin : g_fa
        assign o_sum[g]  = i_a[g] ^ i_b[g] ^ w_c[g];
        assign w_c[g+1]  = (i_a[g] & i_b[g]) | (w_c[g] & (i_a[g] ^ i_b[g]));
    end
    assign o_cout = w_c[4];
endmodule

// File: rtl/nibble_seq_adder.sv
// nibble_seq_adder: W-bit adder that processes one 4-bit slice per clock through a single Adder4bit
//   i_clk : rising-edge clock
//   i_rst : asynchronous active-high reset
//   bus   : slave side of nibble_seq_adder_if (start/operands in, busy/done/sum/cout out)
module nibble_seq_adder
    import nibble_seq_adder_pkg::*;
#(
    parameter int NIBBLES = NIBBLES_DEF
) (
    input  logic                i_clk,
    input  logic                i_rst,
    nibble_seq_adder_if.slave   bus
);
    localparam int W  = 4 * NIBBLES;
    localparam int IW = $clog2(NIBBLES) + 1;

    state_t          r_state;
    state_t          w_state_next;
    logic [IW-1:0]   r_idx;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic            r_carry;
    logic [W-1:0]    r_psum;
    logic [W-1:0]    r_sum;
    logic            r_cout;
    logic [3:0]      w_an;
    logic [3:0]      w_bn;
    logic [3:0]      w_nsum;
    logic            w_ncout;
    logic            w_last;
    logic [W-1:0]    w_psum_next;

    // Current slice of each captured operand, selected by the index
    assign w_an   = 4'(r_a >> (4 * r_idx));
    assign w_bn   = 4'(r_b >> (4 * r_idx));
    assign w_last = (r_idx == IW'(NIBBLES - 1));

    Adder4bit u_add (
        .i_a    (w_an),
        .i_b    (w_bn),
        .i_cin  (r_carry),
        .o_sum  (w_nsum),
        .o_cout (w_ncout)
    );

    // Partial sum with the current slice merged in, so the final edge can load SUM directly
    always_comb begin
        w_psum_next = r_psum;
        for (int k = 0; k < NIBBLES; k++)
            if (r_idx == IW'(k)) w_psum_next[4*k +: 4] = w_nsum;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  w_state_next = bus.i_start ? S_RUN : S_IDLE;
            S_RUN:   w_state_next = w_last ? S_DONE : S_RUN;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_psum  <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (r_state == S_IDLE && bus.i_start) begin
                r_a     <= bus.i_a;
                r_b     <= bus.i_b;
                r_carry <= bus.i_cin;
                r_idx   <= '0;
                r_psum  <= '0;
            end else if (r_state == S_RUN) begin
                r_psum  <= w_psum_next;
                r_carry <= w_ncout;
                r_idx   <= r_idx + 1'b1;
                if (w_last) begin
                    r_sum  <= w_psum_next;
                    r_cout <= w_ncout;
                end
            end
        end
    end

    assign bus.o_busy = (r_state != S_IDLE);
    assign bus.o_done = (r_state == S_DONE);
    assign bus.o_sum  = r_sum;
    assign bus.o_cout = r_cout;
endmodule

// File: tb/tb_nibble_seq_adder.sv
// tb_nibble_seq_adder: directed table-driven bench for nibble_seq_adder plus multi-cycle corner sequences
module tb_nibble_seq_adder;
    import nibble_seq_adder_pkg::*;
    localparam int N = 4;
    localparam int W = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   nchecks = 0;
    int   nerrs   = 0;

    nibble_seq_adder_if #(.W(W)) bus ();

    nibble_seq_adder #(.NIBBLES(N)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] s;
        logic        co;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerrs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic cin,
                          input logic [15:0] es, input logic ec, input string tag);
        int edges = 0;
        @(negedge clk);
        bus.i_a = a;
        bus.i_b = b;
        bus.i_cin = cin;
        bus.i_start = 1'b1;
        @(posedge clk);
        #1;
        bus.i_start = 1'b0;
        bus.i_a = ~a;
        bus.i_b = ~b;
        bus.i_cin = ~cin;
        check({tag, " busy_after_accept"}, 32'(bus.o_busy), 32'd1);
        while (edges < 20) begin
            @(posedge clk);
            #1;
            edges++;
            if (bus.o_done) break;
        end
        check({tag, " latency"}, 32'(edges), 32'(N));
        check({tag, " sum"}, 32'(bus.o_sum), 32'(es));
        check({tag, " cout"}, 32'(bus.o_cout), 32'(ec));
        @(posedge clk);
        #1;
        check({tag, " done_one_cycle"}, 32'(bus.o_done), 32'd0);
        check({tag, " idle_busy"}, 32'(bus.o_busy), 32'd0);
        check({tag, " sum_hold"}, 32'(bus.o_sum), 32'(es));
    endtask

    initial begin
        int ndone;
        int k;
        int last_e;
        logic [15:0] last_sum;
        logic [15:0] exp_s;

        vecs[0] = '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
        vecs[2] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
        vecs[3] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
        vecs[4] = '{16'hABCD, 16'h1111, 1'b0, 16'hBCDE, 1'b0};
        vecs[5] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0};
        vecs[6] = '{16'h7FF8, 16'h0008, 1'b1, 16'h8001, 1'b0};

        bus.i_start = 1'b0;
        bus.i_a = '0;
        bus.i_b = '0;
        bus.i_cin = 1'b0;

        #1;
        check("reset busy", 32'(bus.o_busy), 32'd0);
        check("reset done", 32'(bus.o_done), 32'd0);
        check("reset sum", 32'(bus.o_sum), 32'd0);
        check("reset cout", 32'(bus.o_cout), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 7; i++)
            run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].s, vecs[i].co, $sformatf("vec%0d", i));

        // START pulsed during RUN with different operands must be ignored
        @(negedge clk);
        bus.i_a = 16'h0F0F;
        bus.i_b = 16'h00F1;
        bus.i_cin = 1'b0;
        bus.i_start = 1'b1;
        @(posedge clk);
        #1;
        bus.i_start = 1'b0;
        @(posedge clk);
        #1;
        bus.i_start = 1'b1;
        bus.i_a = 16'hFFFF;
        @(posedge clk);
        #1;
        bus.i_start = 1'b0;
        ndone = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (bus.o_done) begin
                ndone++;
                check("ignore sum", 32'(bus.o_sum), 32'h1000);
                check("ignore cout", 32'(bus.o_cout), 32'd0);
            end
        end
        check("ignore done_count", 32'(ndone), 32'd1);

        // Reset two cycles into an operation aborts it
        @(negedge clk);
        bus.i_a = 16'h1111;
        bus.i_b = 16'h2222;
        bus.i_cin = 1'b0;
        bus.i_start = 1'b1;
        @(posedge clk);
        #1;
        bus.i_start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("abort sum", 32'(bus.o_sum), 32'd0);
        check("abort cout", 32'(bus.o_cout), 32'd0);
        check("abort busy", 32'(bus.o_busy), 32'd0);
        check("abort done", 32'(bus.o_done), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (bus.o_done) ndone++;
        end
        check("abort no_done", 32'(ndone), 32'd0);
        run_op(16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0, "post_reset");

        // START held high: one result every N+2 cycles, SUM stable between pulses
        @(negedge clk);
        k = 0;
        last_e = 0;
        last_sum = '0;
        bus.i_b = 16'h0101;
        bus.i_cin = 1'b0;
        bus.i_a = 16'h0000;
        bus.i_start = 1'b1;
        for (int e = 1; e <= 40; e++) begin
            @(posedge clk);
            #1;
            if (bus.o_done) begin
                exp_s = 16'(16'h1111 * k) + 16'h0101;
                check($sformatf("b2b sum%0d", k), 32'(bus.o_sum), 32'(exp_s));
                if (k > 0) check($sformatf("b2b interval%0d", k), 32'(e - last_e), 32'(N + 2));
                last_e = e;
                last_sum = bus.o_sum;
                k++;
                bus.i_a = 16'(16'h1111 * k);
            end else if (k > 0) begin
                check("b2b sum_stable", 32'(bus.o_sum), 32'(last_sum));
            end
        end
        check("b2b result_count", 32'(k), 32'd6);
        bus.i_start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check("b2b final_idle", 32'(bus.o_busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrs);
        $finish;
    end
endmodule

// File: doc/nibble_seq_adder.md
NIBBLE_SEQ_ADDER -- requirements
Module: nibble_seq_adder

Interface
REQ-001 The block SHALL have parameter NIBBLES, default 4: number of 4-bit slices per operand. Operand width W = 4*NIBBLES.
REQ-002 The block SHALL have port CLK, input, 1 bit: the single clock, rising edge.
REQ-003 The block SHALL have port RST, input, 1 bit: reset. It is asynchronous and active-high.
REQ-004 The block SHALL have port START, input, 1 bit: request to begin an addition. Sampled only in IDLE.
REQ-005 The block SHALL have ports A and B, input, W bits each: the operands. Captured on the accepting edge.
REQ-006 The block SHALL have port CIN, input, 1 bit: carry-in. Captured on the accepting edge.
REQ-007 The block SHALL have port BUSY, output, 1 bit: high while in RUN or DONE.
REQ-008 The block SHALL have port DONE, output, 1 bit: one-cycle result-valid pulse.
REQ-009 The block SHALL have port SUM, output, W bits: registered result.
REQ-010 The block SHALL have port COUT, output, 1 bit: registered carry-out of the top nibble.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-012 In IDLE with START=1 at a rising edge (edge 0), the block SHALL capture A, B and CIN into internal registers. It SHALL clear the nibble index to 0, clear the partial-sum register and enter RUN.
REQ-013 In RUN, each cycle SHALL present operand nibble [4i+3:4i] (i = index) and the carry register to one 4-bit ripple adder.
REQ-014 At each RUN edge, the block SHALL store the 4-bit adder sum into partial-sum nibble i, store the adder carry into the carry register, and increment the index.
REQ-015 After the edge at which index NIBBLES-1 is processed (edge NIBBLES), the block SHALL enter DONE. On that same edge it SHALL load SUM from the partial sum and COUT from the final carry.
REQ-016 DONE SHALL be high for exactly one cycle, the DONE state. The next edge SHALL return the FSM to IDLE unconditionally.
REQ-017 Latency: DONE SHALL be high in the cycle following edge NIBBLES after acceptance (4 edges at default).
REQ-018 Throughput: a new START SHALL be accepted at the earliest on the edge that leaves DONE+1, i.e. in IDLE only. The minimum issue interval is NIBBLES+2 cycles.
REQ-019 START SHALL be ignored in RUN and DONE. Changes on A, B or CIN after acceptance SHALL NOT affect the result in progress.
REQ-020 SUM and COUT SHALL change only on the edge entering DONE. They SHALL hold their value through IDLE until the next completion.
REQ-021 Arithmetic: {COUT,SUM} SHALL equal A + B + CIN, computed as a (W+1)-bit unsigned sum of the captured values.
REQ-022 The index counter SHALL be ceil(log2(NIBBLES))+1 bits wide and SHALL never wrap during an operation.
REQ-023 BUSY SHALL be combinationally decoded from state: 1 in RUN and DONE, 0 in IDLE.

Reset
REQ-024 While RST=1, the block SHALL hold IDLE and index 0, regardless of CLK. SUM, COUT, DONE, BUSY, the carry register and the captured operands SHALL all be 0.
REQ-025 RST asserted mid-RUN SHALL abort the operation immediately. No DONE pulse SHALL follow for it.
REQ-026 After RST deasserts, the first edge with START=1 SHALL be accepted normally.

Structure
REQ-027 The shared package SHALL hold the FSM state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the default NIBBLES constant.
REQ-028 The block SHALL instantiate the existing Adder4bit as its single arithmetic sub-module. It SHALL contain no other adder logic.
REQ-029 All state, index, operand, carry and output registers SHALL reside in nibble_seq_adder.

Verification
REQ-030 Bench SHALL apply A=0x1234, B=0x4321, CIN=1, START pulse -> SUM=0x5556, COUT=0, with DONE high exactly 4 edges after acceptance.
REQ-031 Bench SHALL apply A=0xFFFF, B=0x0001, CIN=0 -> SUM=0x0000, COUT=1 (carry ripples through all nibbles).
REQ-032 Bench SHALL apply A=0xFFFF, B=0xFFFF, CIN=1 -> SUM=0xFFFF, COUT=1. It SHALL then apply A=0x8000, B=0x8000, CIN=0 -> SUM=0x0000, COUT=1.
REQ-033 Bench SHALL start A=0x0F0F, B=0x00F1, CIN=0, then pulse START with A=0xFFFF during RUN -> the second START is ignored, SUM=0x1000, COUT=0, and exactly one DONE pulse occurs.
REQ-034 Bench SHALL assert RST two cycles after acceptance of A=0x1111, B=0x2222 -> SUM=0, COUT=0, BUSY=0 at once and no DONE. A following start with A=0x0001, B=0x0002 -> SUM=0x0003.
REQ-035 Bench SHALL apply back-to-back START held high -> results complete every NIBBLES+2 cycles, and SUM is stable between DONE pulses.
